multicycle_core_param: RTL

//  Parametrised multicycle core: FSM control, 4-entry register file, ALU, PC and flags in one block.

---
 rtl/multicycle_core_param.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_core_param.sv
// Parametrised multicycle core: FSM control, 4-entry register file, ALU, PC and flags,
// with a req/ack memory port that tolerates any number of wait states.
module multicycle_core_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PC_RESET = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_reg,
    output logic [ADDR_W-1:0] pc_out,
    output logic              flag_n,
    output logic              flag_z,
    output logic [2:0]        state,
    output logic              halted
);

    localparam int unsigned RF_N  = 4;
    localparam int unsigned IR_W  = 8;
    localparam int unsigned OFF_W = 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_MEM    = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0]   rf_q [RF_N];
    logic [DATA_W-1:0]   rf_d [RF_N];
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic                n_q, n_d, z_q, z_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [3:0]          op;
    logic [1:0]          ra, rb, wb_dst;
    logic                is_load, is_store, is_ori, is_shift, is_alu, is_branch, is_stop;
    logic                ack_ok, taken;
    logic [DATA_W-1:0]   alu_res;
    logic [ADDR_W-1:0]   br_target;

    // Instruction field decode from the latched IR
    assign op        = ir_q[3:0];
    assign ra        = ir_q[7:6];
    assign rb        = ir_q[5:4];
    assign is_load   = (op == 4'b0000);
    assign is_store  = (op == 4'b0010);
    assign is_stop   = (op == 4'b0001);
    assign is_ori    = (ir_q[2:0] == 3'b111);
    assign is_shift  = (op == 4'b0011);
    assign is_alu    = (op == 4'b0100) || (op == 4'b0110) || (op == 4'b1000) || is_ori || is_shift;
    assign is_branch = (op == 4'b0101) || (op == 4'b1001) || (op == 4'b1101);
    assign wb_dst    = is_ori ? 2'd1 : ra;
    assign ack_ok    = req_q && mem_ack;
    assign br_target = pc_q + {{(ADDR_W-OFF_W){ir_q[7]}}, ir_q[7:4]};

    always_comb begin
        alu_res = '0;
        if (is_ori) begin
            alu_res = rf_q[1] | DATA_W'(ir_q[7:3]);
        end else begin
            case (op)
                4'b0100: alu_res = a_q + b_q;
                4'b0110: alu_res = a_q - b_q;
                4'b1000: alu_res = ~(a_q & b_q);
                4'b0011: alu_res = ir_q[5] ? (a_q >> ir_q[4:3]) : (a_q << ir_q[4:3]);
                default: alu_res = '0;
            endcase
        end
    end

    always_comb begin
        taken = 1'b0;
        case (op)
            4'b0101: taken = z_q;
            4'b1001: taken = !z_q;
            4'b1101: taken = !n_q;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (ack_ok) state_d = S_DECODE;
            S_DECODE: begin
                if (is_load || is_store) state_d = S_MEM;
                else if (is_alu)         state_d = S_EXEC;
                else if (is_branch)      state_d = S_BRANCH;
                else if (is_stop)        state_d = S_HALT;
                else                     state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_MEM:    if (ack_ok) state_d = we_q ? S_FETCH : S_WB;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath and request-port next values; the request for the next state is set up one edge early
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        rf_d    = rf_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        n_d     = n_q;
        z_d     = z_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end else if (mem_ack) begin
                    ir_d  = mem_rdata[IR_W-1:0];
                    pc_d  = pc_q + ADDR_W'(1);
                    req_d = 1'b0;
                end
            end
            S_DECODE: begin
                a_d = rf_q[ra];
                b_d = rf_q[rb];
                if (is_load || is_store) begin
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = ADDR_W'(rf_q[rb]);
                    wdata_d = rf_q[ra];
                end else if (!is_alu && !is_branch && !is_stop) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_q;
                end
            end
            S_EXEC: begin
                res_d = alu_res;
                n_d   = alu_res[DATA_W-1];
                z_d   = (alu_res == '0);
            end
            S_WB: begin
                rf_d[wb_dst] = res_q;
                req_d        = 1'b1;
                we_d         = 1'b0;
                addr_d       = pc_q;
            end
            S_MEM: begin
                if (ack_ok) begin
                    if (we_q) begin
                        req_d  = 1'b1;
                        we_d   = 1'b0;
                        addr_d = pc_q;
                    end else begin
                        res_d = mem_rdata;
                        req_d = 1'b0;
                    end
                end
            end
            S_BRANCH: begin
                if (taken) pc_d = br_target;
                req_d  = 1'b1;
                we_d   = 1'b0;
                addr_d = taken ? br_target : pc_q;
            end
            S_HALT:  req_d = 1'b0;
            default: req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= ADDR_W'(PC_RESET);
            ir_q    <= '0;
            rf_q    <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(PC_RESET);
            wdata_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            n_q     <= n_d;
            z_q     <= z_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_reg   = rf_q[dbg_sel];
    assign pc_out    = pc_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign state     = state_q;
    assign halted    = (state_q == S_HALT);

endmodule
